// File: rtl/intdecl_pkg.sv
// Shared constants, FSM state type and BCD helper for the integer-declaration
// character generator.
package intdecl_pkg;

  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6E;
  localparam logic [7:0] CH_T     = 8'h74;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_SEMI  = 8'h3B;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  localparam logic [6:0] MAX_IDS = 7'd99;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_KW_I,
    ST_KW_N,
    ST_KW_T,
    ST_KW_SP,
    ST_PFX,
    ST_DIG_T,
    ST_DIG_O,
    ST_COMMA,
    ST_SEP_SP,
    ST_SEMI
  } state_e;

  // Last identifier index (count-1, count clamped to MAX_IDS) as {tens, ones}.
  // Repeated subtraction keeps this free of a divider.
  function automatic logic [7:0] last_index_bcd(input logic [6:0] cnt);
    logic [6:0] rem;
    logic [3:0] tens;
    rem  = (cnt > MAX_IDS) ? (MAX_IDS - 7'd1) : (cnt - 7'd1);
    tens = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD index counter with a terminal value captured on clear.
module bcd2_counter
  import intdecl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic [7:0] term_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       at_term_o
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [7:0] term_q, term_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    term_d = term_q;
    if (clr_i) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
      term_d = term_i;
    end else if (inc_i) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      term_q <= 8'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
      term_q <= term_d;
    end
  end

  assign tens_o    = tens_q;
  assign ones_o    = ones_q;
  assign at_term_o = ({tens_q, ones_q} == term_q);

endmodule

// File: rtl/intdecl_gen.sv
// Emits "int v0, v1, ..., vN-1;" one byte per valid/ready transfer,
// with every output driven straight from a register.
module intdecl_gen
  import intdecl_pkg::*;
#(
  parameter logic [7:0] PREFIX    = 8'h76,
  parameter bit         SEP_SPACE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] count,
  output logic [7:0] ch,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  logic [7:0] ch_q, ch_d;
  logic       valid_q, busy_q, done_q, done_d;
  logic       xfer, accept, cnt_clr, cnt_inc, at_term;
  logic [3:0] tens, ones;

  bcd2_counter u_index (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .term_i    (last_index_bcd(count)),
    .tens_o    (tens),
    .ones_o    (ones),
    .at_term_o (at_term)
  );

  assign xfer   = valid_q && ready;
  assign accept = (state_q == ST_IDLE) && start && (count != 7'd0);

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE:   if (accept) begin state_d = ST_KW_I; cnt_clr = 1'b1; end
      ST_KW_I:   if (xfer) state_d = ST_KW_N;
      ST_KW_N:   if (xfer) state_d = ST_KW_T;
      ST_KW_T:   if (xfer) state_d = ST_KW_SP;
      ST_KW_SP:  if (xfer) state_d = ST_PFX;
      ST_PFX:    if (xfer) state_d = (tens != 4'd0) ? ST_DIG_T : ST_DIG_O;
      ST_DIG_T:  if (xfer) state_d = ST_DIG_O;
      ST_DIG_O: begin
        if (xfer) begin
          if (at_term) begin
            state_d = ST_SEMI;
          end else begin
            state_d = ST_COMMA;
            cnt_inc = 1'b1;
          end
        end
      end
      ST_COMMA:  if (xfer) state_d = SEP_SPACE ? ST_SEP_SP : ST_PFX;
      ST_SEP_SP: if (xfer) state_d = ST_PFX;
      ST_SEMI:   if (xfer) begin state_d = ST_IDLE; done_d = 1'b1; end
      default:   state_d = ST_IDLE;
    endcase
  end

  // The index only moves on the DIG_O->COMMA step, so digits read here are
  // already the ones for the state being entered.
  always_comb begin
    ch_d = 8'h00;
    case (state_d)
      ST_KW_I:   ch_d = CH_I;
      ST_KW_N:   ch_d = CH_N;
      ST_KW_T:   ch_d = CH_T;
      ST_KW_SP:  ch_d = CH_SP;
      ST_PFX:    ch_d = PREFIX;
      ST_DIG_T:  ch_d = CH_ZERO + {4'd0, tens};
      ST_DIG_O:  ch_d = CH_ZERO + {4'd0, ones};
      ST_COMMA:  ch_d = CH_COMMA;
      ST_SEP_SP: ch_d = CH_SP;
      ST_SEMI:   ch_d = CH_SEMI;
      default:   ch_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ch_q    <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      valid_q <= (state_d != ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

  assign ch    = ch_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_intdecl_gen.sv
// Directed bench for intdecl_gen: two instances (with and without separator space).
module tb_intdecl_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, start2 = 1'b0;
  logic [6:0] count = 7'd0, count2 = 7'd0;
  logic       ready = 1'b0, ready2 = 1'b0;
  logic [7:0] ch, ch2;
  logic       valid, valid2, busy, busy2, done, done2;

  int n_checks = 0;
  int n_fail   = 0;

  intdecl_gen #(.PREFIX(8'h76), .SEP_SPACE(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .ch(ch), .valid(valid), .ready(ready), .busy(busy), .done(done)
  );

  intdecl_gen #(.PREFIX(8'h76), .SEP_SPACE(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .start(start2), .count(count2),
    .ch(ch2), .valid(valid2), .ready(ready2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int which, input logic [6:0] c);
    if (which == 0) begin start = 1'b1; count = c; end
    else begin start2 = 1'b1; count2 = c; end
    step();
    start = 1'b0;
    start2 = 1'b0;
  endtask

  // Drains one stream; returns captured text and post-';' status (the done cycle).
  task automatic capture(input int which, input int duty, input int inject_at,
                         output string s, output int xfers, output int vcycles,
                         output int stall_bad, output logic done_o,
                         output logic busy_o, output logic valid_o,
                         output bit timed_out);
    logic       v, r, prev_stall, semi;
    logic [7:0] c, prev_ch;
    s = ""; xfers = 0; vcycles = 0; stall_bad = 0;
    prev_stall = 1'b0; prev_ch = 8'h00; semi = 1'b0; timed_out = 1'b1;
    done_o = 1'b0; busy_o = 1'b0; valid_o = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      v = (which == 0) ? valid : valid2;
      c = (which == 0) ? ch : ch2;
      if (prev_stall && (!v || c !== prev_ch)) stall_bad++;
      r = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      if (which == 0) ready = r; else ready2 = r;
      if (cyc == inject_at) begin start = 1'b1; count = 7'd5; end
      if (v) vcycles++;
      if (v && r) begin
        s = $sformatf("%s%c", s, c);
        xfers++;
        semi = (c == 8'h3B);
      end
      prev_stall = v && !r;
      prev_ch = c;
      step();
      start = 1'b0;
      if (semi) begin
        done_o  = (which == 0) ? done : done2;
        busy_o  = (which == 0) ? busy : busy2;
        valid_o = (which == 0) ? valid : valid2;
        timed_out = 1'b0;
        break;
      end
    end
    ready = 1'b0;
    ready2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++;
    if ({ch, valid, busy, done} !== {8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: ch=%h valid=%b busy=%b done=%b, required 00/0/0/0", ch, valid, busy, done);
    end
    n_checks++;
    if ({ch2, valid2, busy2, done2} !== {8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state_ns: ch=%h valid=%b busy=%b done=%b, required 00/0/0/0", ch2, valid2, busy2, done2);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_count1();
    string s; int x, vc, sb; logic d, b, v; bit to;
    do_start(0, 7'd1);
    n_checks++;
    if (!(valid === 1'b1 && ch === 8'h69)) begin
      n_fail++;
      $display("FAIL first_char: valid=%b ch=%h, required 1/69", valid, ch);
    end
    capture(0, 100, -1, s, x, vc, sb, d, b, v, to);
    n_checks++;
    if (to || s != "int v0;" || x != 7) begin
      n_fail++;
      $display("FAIL count1_stream: got '%s' (%0d xfers, timeout=%0d), required 'int v0;' (7)", s, x, to);
    end
    n_checks++;
    if ({d, b, v} !== 3'b100) begin
      n_fail++;
      $display("FAIL count1_done: done/busy/valid=%b%b%b, required 100", d, b, v);
    end
    step();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: done=%b a cycle later, required 0", done);
    end
  endtask

  task automatic test_back_to_back();
    string s; int x, vc, sb; logic d, b, v; bit to;
    do_start(0, 7'd1);
    capture(0, 100, -1, s, x, vc, sb, d, b, v, to);
    do_start(0, 7'd3);
    n_checks++;
    if (!(valid === 1'b1 && ch === 8'h69)) begin
      n_fail++;
      $display("FAIL b2b_restart: valid=%b ch=%h, required 1/69", valid, ch);
    end
    capture(0, 100, -1, s, x, vc, sb, d, b, v, to);
    n_checks++;
    if (to || s != "int v0, v1, v2;" || x != 15 || vc != 15) begin
      n_fail++;
      $display("FAIL count3_stream: got '%s' xfers=%0d valid_cycles=%0d, required 'int v0, v1, v2;' 15/15", s, x, vc);
    end
    n_checks++;
    if (d !== 1'b1) begin
      n_fail++;
      $display("FAIL count3_done: done=%b, required 1", d);
    end
  endtask

  task automatic test_no_sep();
    string s; int x, vc, sb; logic d, b, v; bit to;
    do_start(1, 7'd12);
    capture(1, 100, -1, s, x, vc, sb, d, b, v, to);
    n_checks++;
    if (to || s != "int v0,v1,v2,v3,v4,v5,v6,v7,v8,v9,v10,v11;" || x != 42) begin
      n_fail++;
      $display("FAIL nosep_stream: got '%s' (%0d), required 'int v0,v1,v2,v3,v4,v5,v6,v7,v8,v9,v10,v11;' (42)", s, x);
    end
  endtask

  task automatic test_stall();
    string s; int x, vc, sb; logic d, b, v; bit to;
    do_start(0, 7'd4);
    capture(0, 30, -1, s, x, vc, sb, d, b, v, to);
    n_checks++;
    if (to || s != "int v0, v1, v2, v3;" || x != 19) begin
      n_fail++;
      $display("FAIL stall_stream: got '%s' (%0d, timeout=%0d), required 'int v0, v1, v2, v3;' (19)", s, x, to);
    end
    n_checks++;
    if (sb != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d stalled cycles changed ch or dropped valid, required 0", sb);
    end
  endtask

  task automatic test_ignored_start();
    string s; int x, vc, sb, bad; logic d, b, v; bit to;
    start = 1'b1; count = 7'd0;
    step();
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0 || valid !== 1'b0) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL count0_ignored: %0d cycles with busy/valid set, required 0", bad);
    end
    do_start(0, 7'd2);
    capture(0, 100, 3, s, x, vc, sb, d, b, v, to);
    n_checks++;
    if (to || s != "int v0, v1;") begin
      n_fail++;
      $display("FAIL midstart_stream: got '%s', required 'int v0, v1;'", s);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midstart_no_restart: busy=%b valid=%b, required 0/0", busy, valid);
    end
  endtask

  task automatic test_clamp();
    string s, tail; int x, vc, sb; logic d, b, v; bit to;
    do_start(0, 7'd120);
    capture(0, 100, -1, s, x, vc, sb, d, b, v, to);
    tail = (s.len() >= 6) ? s.substr(s.len() - 6, s.len() - 1) : s;
    n_checks++;
    if (to || x != 488 || tail != ", v98;") begin
      n_fail++;
      $display("FAIL clamp_99: xfers=%0d tail='%s', required 488 ', v98;'", x, tail);
    end
  endtask

  task automatic test_reset_mid();
    string s; int x, vc, sb, bad; logic d, b, v; bit to;
    do_start(0, 7'd5);
    ready = 1'b1;
    repeat (6) step();
    reset = 1'b1;
    ready = 1'b0;
    step();
    n_checks++;
    if ({ch, valid, busy, done} !== {8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid: ch=%h valid=%b busy=%b done=%b, required 00/0/0/0", ch, valid, busy, done);
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (done !== 1'b0 || valid !== 1'b0) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d cycles with done/valid after reset, required 0", bad);
    end
    start = 1'b1; count = 7'd3; reset = 1'b1;
    step();
    start = 1'b0; reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wins: busy=%b valid=%b, required 0/0", busy, valid);
    end
    do_start(0, 7'd2);
    capture(0, 100, -1, s, x, vc, sb, d, b, v, to);
    n_checks++;
    if (to || s != "int v0, v1;" || x != 11 || d !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_stream: got '%s' (%0d) done=%b, required 'int v0, v1;' (11) 1", s, x, d);
    end
  endtask

  initial begin
    test_reset();
    test_count1();
    test_back_to_back();
    test_no_sep();
    test_stall();
    test_ignored_start();
    test_clamp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
